// File: rtl/fpu_vector_runner.sv
// On-chip FPU test sequencer: replays stored vectors through the FPU busy handshake,
// keeps each 32-bit result in a readable buffer and tallies pass/fail/timeout.
module fpu_vector_runner #(
  parameter int DEPTH   = 1024,
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255,
  parameter bit NAN_BOX = 1'b1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic [2:0]      load_sel,
  input  logic [AW-1:0]   load_addr,
  input  logic [31:0]     load_data,
  input  logic            start,
  input  logic [AW:0]     count,
  input  logic            nan_any,
  output logic            running_o,
  output logic            done_o,
  output logic [AW:0]     pass_cnt_o,
  output logic [AW:0]     fail_cnt_o,
  output logic [AW-1:0]   first_fail_o,
  output logic            timeout_o,
  output logic [31:0]     fpu_instr_o,
  output logic [XLEN-1:0] fpu_rs1_o,
  output logic [XLEN-1:0] fpu_rs2_o,
  output logic [XLEN-1:0] fpu_rs3_o,
  input  logic            fpu_busy_i,
  input  logic [XLEN-1:0] fpu_out_i,
  input  logic [AW-1:0]   rd_addr,
  output logic [31:0]     rd_data_o
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_FIN} state_t;

  state_t          state;
  logic [31:0]     mem_a [DEPTH];
  logic [31:0]     mem_b [DEPTH];
  logic [31:0]     mem_c [DEPTH];
  logic [31:0]     mem_e [DEPTH];
  logic [31:0]     mem_i [DEPTH];
  logic [31:0]     mem_r [DEPTH];
  logic [AW-1:0]   idx, nidx;
  logic [AW:0]     cnt_q, count_sat;
  logic            nan_q, to_q, cap, tmo, last, pass_v;
  logic [TW-1:0]   wcnt;
  logic [31:0]     res_q, exp_q;
  logic            unused_hi;

  assign unused_hi = ^fpu_out_i[XLEN-1:32];

  function automatic logic [XLEN-1:0] box(input logic [31:0] w);
    logic [XLEN-1:0] r;
    r = NAN_BOX ? '1 : '0;
    r[31:0] = w;
    return r;
  endfunction

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  assign count_sat = (count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : count;
  // Slot to issue next: slot 0 when leaving IDLE, idx+1 when leaving CHECK.
  assign nidx   = (state == S_CHECK) ? idx + AW'(1) : '0;
  assign cap    = (state == S_WAIT) && !fpu_busy_i;
  assign tmo    = (state == S_WAIT) && fpu_busy_i && (wcnt == TW'(TIMEOUT - 1));
  assign last   = ((AW+1)'(idx) + (AW+1)'(1)) == cnt_q;
  assign pass_v = !to_q && ((res_q == exp_q) || (nan_q && is_nan(res_q) && is_nan(exp_q)));

  always_ff @(posedge clk) begin
    if (load_en && state == S_IDLE) begin
      case (load_sel)
        3'd0: mem_a[load_addr] <= load_data;
        3'd1: mem_b[load_addr] <= load_data;
        3'd2: mem_c[load_addr] <= load_data;
        3'd3: mem_e[load_addr] <= load_data;
        3'd4: mem_i[load_addr] <= load_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (cap || tmo)) mem_r[idx] <= cap ? fpu_out_i[31:0] : 32'hFFFF_FFFF;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_o <= '0;
    else     rd_data_o <= mem_r[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      cnt_q        <= '0;
      nan_q        <= 1'b0;
      to_q         <= 1'b0;
      wcnt         <= '0;
      res_q        <= '0;
      exp_q        <= '0;
      running_o    <= 1'b0;
      done_o       <= 1'b0;
      pass_cnt_o   <= '0;
      fail_cnt_o   <= '0;
      first_fail_o <= '0;
      timeout_o    <= 1'b0;
      fpu_instr_o  <= NOP;
      fpu_rs1_o    <= '0;
      fpu_rs2_o    <= '0;
      fpu_rs3_o    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done_o <= 1'b0;
          if (start) begin
            cnt_q        <= count_sat;
            nan_q        <= nan_any;
            pass_cnt_o   <= '0;
            fail_cnt_o   <= '0;
            first_fail_o <= '0;
            timeout_o    <= 1'b0;
            idx          <= '0;
            running_o    <= 1'b1;
            if (count_sat == '0) begin
              state  <= S_FIN;
              done_o <= 1'b1;
            end else begin
              state       <= S_ISSUE;
              fpu_instr_o <= mem_i[nidx];
              fpu_rs1_o   <= box(mem_a[nidx]);
              fpu_rs2_o   <= box(mem_b[nidx]);
              fpu_rs3_o   <= box(mem_c[nidx]);
              exp_q       <= mem_e[nidx];
            end
          end
        end
        S_ISSUE: begin
          wcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cap || tmo) begin
            res_q       <= cap ? fpu_out_i[31:0] : 32'hFFFF_FFFF;
            to_q        <= tmo;
            fpu_instr_o <= NOP;
            state       <= S_CHECK;
            if (tmo) timeout_o <= 1'b1;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        end
        S_CHECK: begin
          if (pass_v) begin
            pass_cnt_o <= pass_cnt_o + (AW+1)'(1);
          end else begin
            fail_cnt_o <= fail_cnt_o + (AW+1)'(1);
            if (fail_cnt_o == '0) first_fail_o <= idx;
          end
          if (last) begin
            state  <= S_FIN;
            done_o <= 1'b1;
          end else begin
            idx         <= nidx;
            state       <= S_ISSUE;
            fpu_instr_o <= mem_i[nidx];
            fpu_rs1_o   <= box(mem_a[nidx]);
            fpu_rs2_o   <= box(mem_b[nidx]);
            fpu_rs3_o   <= box(mem_c[nidx]);
            exp_q       <= mem_e[nidx];
          end
        end
        S_FIN: begin
          done_o    <= 1'b0;
          running_o <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_vector_runner.sv
// Random and directed runs against a mock FPU; expected counts, timing and result
// buffer contents come from a per-vector reference model kept in this bench.
module tb_fpu_vector_runner;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int XLEN = 64;
  localparam int TMO = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 0, rst = 1;
  logic load_en = 0, start = 0, nan_any = 0, fpu_busy_i = 0;
  logic [2:0] load_sel = 0;
  logic [AW-1:0] load_addr = 0, rd_addr = 0, first_fail_o;
  logic [31:0] load_data = 0, fpu_instr_o, rd_data_o;
  logic [AW:0] count = 0, pass_cnt_o, fail_cnt_o;
  logic running_o, done_o, timeout_o;
  logic [XLEN-1:0] fpu_rs1_o, fpu_rs2_o, fpu_rs3_o, fpu_out_i = 0;

  fpu_vector_runner #(.DEPTH(DEPTH), .XLEN(XLEN), .TIMEOUT(TMO), .NAN_BOX(1'b1)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_sel(load_sel), .load_addr(load_addr),
    .load_data(load_data), .start(start), .count(count), .nan_any(nan_any),
    .running_o(running_o), .done_o(done_o), .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o),
    .first_fail_o(first_fail_o), .timeout_o(timeout_o), .fpu_instr_o(fpu_instr_o),
    .fpu_rs1_o(fpu_rs1_o), .fpu_rs2_o(fpu_rs2_o), .fpu_rs3_o(fpu_rs3_o),
    .fpu_busy_i(fpu_busy_i), .fpu_out_i(fpu_out_i), .rd_addr(rd_addr), .rd_data_o(rd_data_o));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [31:0] ma [DEPTH], mb [DEPTH], mc [DEPTH], me [DEPTH], mi [DEPTH];
  logic [31:0] mout [DEPTH], mres [DEPTH];
  int mlat [DEPTH];
  int mock_idx = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Mock FPU: busy for mlat[] WAIT cycles after each new instruction, then returns mout[].
  int k = 0, cur = 0;
  always @(negedge clk) begin
    if (fpu_instr_o !== NOP) begin
      if (k == 0) begin
        cur = mock_idx;
        mock_idx++;
        chk("rs1", fpu_rs1_o, {32'hFFFF_FFFF, ma[cur]});
        chk("rs2", fpu_rs2_o, {32'hFFFF_FFFF, mb[cur]});
        chk("rs3", fpu_rs3_o, {32'hFFFF_FFFF, mc[cur]});
        chk("instr", fpu_instr_o, mi[cur]);
      end
      k++;
      fpu_busy_i = (k == 1) || (k - 1 <= mlat[cur]);
      fpu_out_i = {$urandom, mout[cur]};
    end else begin
      k = 0;
      fpu_busy_i = 0;
    end
  end

  function automatic logic is_nan(input logic [31:0] v);
    return v[30:23] == 8'hFF && v[22:0] != 0;
  endfunction

  task automatic load(input logic [2:0] sel, input int addr, input logic [31:0] d);
    load_en = 1; load_sel = sel; load_addr = addr[AW-1:0]; load_data = d;
    @(negedge clk);
    load_en = 0;
  endtask

  task automatic load_vecs(input int n);
    for (int i = 0; i < n; i++) begin
      load(3'd0, i, ma[i]); load(3'd1, i, mb[i]); load(3'd2, i, mc[i]);
      load(3'd3, i, me[i]); load(3'd4, i, mi[i]);
    end
  endtask

  task automatic gen_vecs(input int n);
    for (int i = 0; i < n; i++) begin
      ma[i] = $urandom; mb[i] = $urandom; mc[i] = $urandom; mi[i] = $urandom;
      if (mi[i] == NOP) mi[i] = 32'h53;
      case ($urandom_range(3))
        0, 1: begin me[i] = $urandom; mout[i] = me[i]; end
        2: begin me[i] = $urandom; mout[i] = me[i] ^ (32'h1 << $urandom_range(31)); end
        default: begin
          me[i] = {1'b0, 8'hFF, 23'h400000 | 23'($urandom)};
          mout[i] = {1'b1, 8'hFF, 23'h000001 | 23'($urandom)};
        end
      endcase
      mlat[i] = ($urandom_range(7) == 0) ? $urandom_range(TMO, TMO + 2) : $urandom_range(3);
    end
    load_vecs(n);
  endtask

  task automatic run(input string tag, input int req, input logic nan);
    int n, ep, ef, efirst, ecyc, cyc, nonnop, w;
    logic eto, ok;
    n = (req > DEPTH) ? DEPTH : req;
    ep = 0; ef = 0; efirst = 0; eto = 0; ecyc = 1;
    for (int i = 0; i < n; i++) begin
      w = (mlat[i] < TMO) ? mlat[i] + 1 : TMO;
      ecyc += 2 + w;
      mres[i] = (mlat[i] >= TMO) ? 32'hFFFF_FFFF : mout[i];
      ok = (mlat[i] < TMO) && (mres[i] == me[i] || (nan && is_nan(mres[i]) && is_nan(me[i])));
      if (mlat[i] >= TMO) eto = 1;
      if (ok) ep++;
      else begin
        if (ef == 0) efirst = i;
        ef++;
      end
    end
    mock_idx = 0;
    count = req[AW:0]; nan_any = nan; start = 1;
    cyc = 0; nonnop = 0;
    while (1) begin
      @(negedge clk);
      start = 0;
      cyc++;
      // writes during a run must not reach the store
      if (n > 0 && cyc == 2) begin
        load_en = 1; load_sel = 3'd3; load_addr = 0; load_data = ~me[0];
      end
      if (cyc == 3) load_en = 0;
      if (fpu_instr_o !== NOP) nonnop++;
      if (done_o === 1'b1 || cyc > 3000) break;
    end
    load_en = 0;
    chk({tag, ".done_cyc"}, cyc, ecyc);
    chk({tag, ".pass"}, pass_cnt_o, ep);
    chk({tag, ".fail"}, fail_cnt_o, ef);
    chk({tag, ".timeout"}, timeout_o, eto);
    chk({tag, ".running_at_done"}, running_o, 1);
    if (ef != 0) chk({tag, ".first_fail"}, first_fail_o, efirst);
    if (n == 0) chk({tag, ".nonnop"}, nonnop, 0);
    @(negedge clk);
    chk({tag, ".after_done"}, {running_o, done_o, fpu_instr_o}, {2'b00, NOP});
    for (int i = 0; i < n; i++) begin
      rd_addr = i[AW-1:0];
      @(negedge clk);
      chk({tag, ".rd"}, rd_data_o, mres[i]);
    end
  endtask

  initial begin
    int seen, budget;
    for (int i = 0; i < DEPTH; i++) begin
      ma[i] = 0; mb[i] = 0; mc[i] = 0; me[i] = 0; mi[i] = 32'h53; mout[i] = 0; mlat[i] = 0;
    end
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst.ctrl", {running_o, done_o, timeout_o, first_fail_o}, 0);
    chk("rst.cnt", {pass_cnt_o, fail_cnt_o}, 0);
    chk("rst.instr", fpu_instr_o, NOP);
    chk("rst.ops", fpu_rs1_o | fpu_rs2_o | fpu_rs3_o, 0);
    chk("rst.rd", rd_data_o, 0);

    // single FADD.S
    ma[0] = 32'h3F80_0000; mb[0] = 32'h4000_0000; mc[0] = 0; me[0] = 32'h4040_0000;
    mi[0] = 32'h53; mout[0] = 32'h4040_0000; mlat[0] = 3;
    load_vecs(1);
    run("fadd", 1, 0);

    // four vectors, vector 2 off by one ulp
    for (int i = 0; i < 4; i++) begin
      ma[i] = $urandom; mb[i] = $urandom; mc[i] = $urandom; mi[i] = 32'h53 + (i << 25);
      me[i] = 32'h4040_0000; mout[i] = (i == 2) ? 32'h4040_0001 : 32'h4040_0000; mlat[i] = i;
    end
    load_vecs(4);
    run("four", 4, 0);

    // FPU never drops busy
    mlat[0] = 50; me[0] = 32'h1234_5678; mout[0] = 32'h1234_5678;
    load_vecs(1);
    run("timeout", 1, 0);

    // NaN equivalence
    me[0] = 32'h7FC0_0000; mout[0] = 32'h7F80_0001; mlat[0] = 1;
    load_vecs(1);
    run("nan1", 1, 1);
    run("nan0", 1, 0);

    run("zero", 0, 0);

    // reset while vector 5 is in WAIT
    gen_vecs(8);
    for (int i = 0; i < 8; i++) mlat[i] = 2;
    mock_idx = 0; count = 8; nan_any = 0; start = 1;
    @(negedge clk);
    start = 0;
    budget = 0;
    while (mock_idx < 6 && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    chk("rstmid.reach", budget < 500, 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rstmid.state", {running_o, done_o, fpu_instr_o}, {2'b00, NOP});
    chk("rstmid.cnt", {pass_cnt_o, fail_cnt_o}, 0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_o !== 1'b0) seen++;
    end
    chk("rstmid.nodone", seen, 0);
    run("rerun", 8, 0);

    // random runs, including full depth and a saturated count
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      gen_vecs(n);
      run("rand", n, 1'($urandom_range(1)));
    end
    gen_vecs(DEPTH);
    run("full", DEPTH, 1);
    run("sat", DEPTH + 5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
